// File: rtl/trng_ro_pool_if.sv
// Valid/ready word stream from the entropy pool to its consumer.
// The master drives valid and data; the slave drives ready.
interface trng_ro_pool_if #(
   parameter int OUT_W = 8
);
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;

   modport master (output out_valid, output out_data, input out_ready);
   modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/trng_ro_pool.sv
// Ring-oscillator entropy collector: synchronise, XOR-mix, health-test,
// optionally von Neumann debias, pack into words and queue in a small FIFO.
module trng_ro_pool #(
   parameter int N_CH      = 4,
   parameter int OUT_W     = 8,
   parameter int DEPTH     = 4,
   parameter int DIV_W     = 8,
   parameter int REP_LIMIT = 32
) (
   input  logic                         CLK,
   input  logic                         RSTn,
   input  logic                         en,
   input  logic                         debias,
   input  logic [DIV_W-1:0]             div,
   input  logic [N_CH-1:0]              ch_mask,
   input  logic [N_CH-1:0]              ro_in,
   trng_ro_pool_if.master               out_if,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         alarm,
   output logic                         overflow,
   input  logic                         status_clr
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int RW = $clog2(REP_LIMIT+1);
   localparam int BW = $clog2(OUT_W);

   logic [N_CH-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [RW-1:0]    rep_cnt_q, rep_cnt_d;
   logic             last_q, last_d;
   logic             alarm_q, alarm_d;
   logic             overflow_q, overflow_d;
   logic             phase_q, phase_d;
   logic             first_q, first_d;
   logic [OUT_W-2:0] part_q, part_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [OUT_W-1:0] mem_q [DEPTH];
   logic [OUT_W-1:0] mem_d [DEPTH];

   logic             mix, tick, rep_hit, sample_ok, acc, acc_bit;
   logic             push, pop, full, push_ok, drop;
   logic [RW-1:0]    rep_nxt;
   logic [OUT_W-1:0] word;

   always_comb begin
      sync1_d   = ro_in;
      sync2_d   = sync1_q;
      mix       = ^(sync2_q & ch_mask);

      tick      = 1'b0;
      div_cnt_d = '0;
      if (en) begin
         if (div_cnt_q == div) tick = 1'b1;
         else                  div_cnt_d = div_cnt_q + DIV_W'(1);
      end

      // rep_cnt of 0 marks "no sample seen since reset/clear"
      rep_nxt = rep_cnt_q;
      if (tick) begin
         if (rep_cnt_q == '0 || mix != last_q)   rep_nxt = RW'(1);
         else if (rep_cnt_q != RW'(REP_LIMIT))   rep_nxt = rep_cnt_q + RW'(1);
      end
      rep_hit   = tick && (rep_nxt == RW'(REP_LIMIT));
      sample_ok = tick && !alarm_q && !rep_hit;

      acc     = 1'b0;
      acc_bit = mix;
      phase_d = phase_q;
      first_d = first_q;
      if (sample_ok) begin
         if (!debias) begin
            acc = 1'b1;
         end else if (!phase_q) begin
            phase_d = 1'b1;
            first_d = mix;
         end else begin
            phase_d = 1'b0;
            acc     = (first_q != mix);
            acc_bit = first_q;
         end
      end
      if (!debias) phase_d = 1'b0;

      // Earliest bit ends at the MSB; the final bit completes the word directly.
      word      = {part_q, acc_bit};
      part_d    = part_q;
      bit_cnt_d = bit_cnt_q;
      push      = 1'b0;
      if (acc) begin
         part_d = word[OUT_W-2:0];
         if (bit_cnt_q == BW'(OUT_W-1)) begin
            push      = 1'b1;
            bit_cnt_d = '0;
         end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
         end
      end

      pop      = (count_q != '0) && out_if.out_ready;
      full     = (count_q == CW'(DEPTH));
      push_ok  = push && (!full || pop);
      drop     = push && full && !pop;

      rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      mem_d    = mem_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = word;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      unique case ({push_ok, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      alarm_d    = alarm_q | rep_hit;
      overflow_d = overflow_q | drop;
      rep_cnt_d  = rep_nxt;
      last_d     = tick ? mix : last_q;
      if (status_clr) begin
         alarm_d    = 1'b0;
         overflow_d = 1'b0;
         rep_cnt_d  = '0;
         last_d     = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         div_cnt_q  <= '0;
         rep_cnt_q  <= '0;
         last_q     <= 1'b0;
         alarm_q    <= 1'b0;
         overflow_q <= 1'b0;
         phase_q    <= 1'b0;
         first_q    <= 1'b0;
         part_q     <= '0;
         bit_cnt_q  <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         mem_q      <= '{default: '0};
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         div_cnt_q  <= div_cnt_d;
         rep_cnt_q  <= rep_cnt_d;
         last_q     <= last_d;
         alarm_q    <= alarm_d;
         overflow_q <= overflow_d;
         phase_q    <= phase_d;
         first_q    <= first_d;
         part_q     <= part_d;
         bit_cnt_q  <= bit_cnt_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         mem_q      <= mem_d;
      end
   end

   assign out_if.out_valid = (count_q != '0);
   assign out_if.out_data  = mem_q[rd_ptr_q];
   assign count            = count_q;
   assign alarm            = alarm_q;
   assign overflow         = overflow_q;
endmodule

// File: tb/tb_trng_ro_pool.sv
// Bench for trng_ro_pool: directed vector table, hand-written corner sequences
// and randomized traffic, all checked against a queue-based reference model.
module tb_trng_ro_pool;
   logic       CLK;
   logic       RSTn;
   logic       en;
   logic       debias;
   logic [7:0] div;
   logic [3:0] ch_mask;
   logic [3:0] ro_in;
   logic [2:0] count;
   logic       alarm;
   logic       overflow;
   logic       status_clr;

   trng_ro_pool_if #(.OUT_W(8)) bus ();

   trng_ro_pool #(.N_CH(4), .OUT_W(8), .DEPTH(4), .DIV_W(8), .REP_LIMIT(32)) dut (
      .CLK        (CLK),
      .RSTn       (RSTn),
      .en         (en),
      .debias     (debias),
      .div        (div),
      .ch_mask    (ch_mask),
      .ro_in      (ro_in),
      .out_if     (bus.master),
      .count      (count),
      .alarm      (alarm),
      .overflow   (overflow),
      .status_clr (status_clr)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: bit and word queues driven by the behavioural rules.
   logic [3:0] h0, h1;
   int         dcnt, run;
   bit         last_b, m_alarm, m_ovf, have_first, first_b, armed, data_zero;
   bit         bitsq[$];
   logic [7:0] fifo[$];

   task automatic model_step();
      bit m, tick, keep, al_set, ov_set;
      int run_new;
      logic [7:0] w;
      if (!RSTn) begin
         h0 = '0; h1 = '0; dcnt = 0; run = 0; last_b = 0;
         m_alarm = 0; m_ovf = 0; have_first = 0; first_b = 0;
         bitsq.delete(); fifo.delete();
         armed = 1; data_zero = 1;
         return;
      end
      m  = ^(h1 & ch_mask);
      h1 = h0;
      h0 = ro_in;
      tick = 0;
      if (en) begin
         if (dcnt == int'(div)) begin tick = 1; dcnt = 0; end
         else dcnt = (dcnt + 1) % 256;
      end else begin
         dcnt = 0;
      end
      al_set = 0; ov_set = 0; run_new = run;
      if (tick) begin
         if (run == 0 || m != last_b) run_new = 1;
         else run_new = (run + 1 > 32) ? 32 : run + 1;
         al_set = (run_new == 32);
         keep   = !m_alarm && !al_set;
         if (keep) begin
            if (!debias) bitsq.push_back(m);
            else if (!have_first) begin first_b = m; have_first = 1; end
            else begin
               if (first_b != m) bitsq.push_back(first_b);
               have_first = 0;
            end
         end
         last_b = m;
      end
      run = run_new;
      if (!debias) have_first = 0;
      if (fifo.size() > 0 && bus.out_ready) void'(fifo.pop_front());
      if (bitsq.size() == 8) begin
         w = '0;
         foreach (bitsq[i]) w = {w[6:0], bitsq[i]};
         bitsq.delete();
         if (fifo.size() < 4) begin fifo.push_back(w); data_zero = 0; end
         else ov_set = 1;
      end
      if (status_clr) begin
         m_alarm = 0; m_ovf = 0; run = 0; last_b = 0;
      end else begin
         m_alarm = m_alarm | al_set;
         m_ovf   = m_ovf | ov_set;
      end
   endtask

   task automatic model_check();
      if (!armed) return;
      chk("out_valid", 32'(bus.out_valid), 32'(fifo.size() > 0));
      chk("count", 32'(count), 32'(fifo.size()));
      chk("alarm", 32'(alarm), 32'(m_alarm));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (fifo.size() > 0) chk("out_data", 32'(bus.out_data), 32'(fifo[0]));
      else if (data_zero)  chk("out_data_rst", 32'(bus.out_data), 32'h0);
   endtask

   // Inputs change only at the falling edge; outputs are checked there too.
   task automatic tick1();
      @(posedge CLK);
      model_step();
      @(negedge CLK);
      model_check();
   endtask

   function automatic bit srcbit(int kind, int j);
      logic [7:0] p;
      p = 8'b0110_0011;
      case (kind)
         1:       return (j % 2) == 1;
         2:       return p[7 - (j % 8)];
         3:       return ((j / 4) % 2) == 1;
         default: return 1'b0;
      endcase
   endfunction

   typedef struct {
      logic [3:0] mask;
      logic [3:0] ro_a;
      logic [3:0] ro_b;
      logic [7:0] dv;
      bit         db;
      int         kind;
      int         ncyc;
      int         exp_cnt;
      bit         exp_al;
      bit         exp_ov;
      int         exp_word;
   } vec_t;

   vec_t tab[$];

   function automatic void add(logic [3:0] mask, logic [3:0] ro_a, logic [3:0] ro_b,
                               logic [7:0] dv, bit db, int kind, int ncyc,
                               int exp_cnt, bit exp_al, bit exp_ov, int exp_word);
      vec_t v;
      v.mask = mask; v.ro_a = ro_a; v.ro_b = ro_b; v.dv = dv; v.db = db;
      v.kind = kind; v.ncyc = ncyc; v.exp_cnt = exp_cnt; v.exp_al = exp_al;
      v.exp_ov = exp_ov; v.exp_word = exp_word;
      tab.push_back(v);
   endfunction

   // Reset, two cycles of synchroniser fill with en=0, then ncyc enabled cycles.
   task automatic run_row(vec_t v);
      RSTn = 1'b0; en = 1'b0; status_clr = 1'b0; bus.out_ready = 1'b0;
      debias = v.db; div = v.dv; ch_mask = v.mask; ro_in = '0;
      tick1();
      RSTn = 1'b1;
      for (int j = 0; j < v.ncyc + 2; j++) begin
         ro_in = srcbit(v.kind, j) ? v.ro_b : v.ro_a;
         en    = (j >= 2);
         tick1();
      end
      en = 1'b0;
   endtask

   bit tg;

   initial begin
      RSTn = 1'b0; en = 1'b0; debias = 1'b0; div = '0; ch_mask = '0; ro_in = '0;
      status_clr = 1'b0; bus.out_ready = 1'b0; armed = 0;

      add(4'b0001, 4'b0000, 4'b0000, 8'd0, 0, 0, 31, 3, 0, 0, 8'h00);
      add(4'b0001, 4'b0000, 4'b0000, 8'd0, 0, 0, 32, 3, 1, 0, 8'h00);
      add(4'b0001, 4'b0000, 4'b0000, 8'd0, 0, 0, 40, 3, 1, 0, 8'h00);
      add(4'b0010, 4'b0010, 4'b0010, 8'd0, 0, 0, 40, 3, 1, 0, 8'hFF);
      add(4'b0001, 4'b0000, 4'b0001, 8'd0, 0, 1, 36, 4, 0, 0, 8'h55);
      add(4'b0001, 4'b0000, 4'b0001, 8'd0, 0, 1, 40, 4, 0, 1, 8'h55);
      add(4'b1111, 4'b0111, 4'b0110, 8'd0, 0, 1, 16, 2, 0, 0, 8'hAA);
      add(4'b1000, 4'b0111, 4'b1111, 8'd0, 0, 1,  7, 0, 0, 0, -1);
      add(4'b1000, 4'b0111, 4'b1111, 8'd0, 0, 1,  8, 1, 0, 0, 8'h55);
      add(4'b0001, 4'b0000, 4'b0001, 8'd0, 1, 2, 27, 0, 0, 0, -1);
      add(4'b0001, 4'b0000, 4'b0001, 8'd0, 1, 2, 28, 1, 0, 0, 8'h55);
      add(4'b0001, 4'b0000, 4'b0001, 8'd3, 0, 3, 31, 0, 0, 0, -1);
      add(4'b0001, 4'b0000, 4'b0001, 8'd3, 0, 3, 32, 1, 0, 0, 8'h55);

      for (int r = 0; r < tab.size(); r++) begin
         run_row(tab[r]);
         chk($sformatf("row%0d_count", r), 32'(count), 32'(tab[r].exp_cnt));
         chk($sformatf("row%0d_alarm", r), 32'(alarm), 32'(tab[r].exp_al));
         chk($sformatf("row%0d_overflow", r), 32'(overflow), 32'(tab[r].exp_ov));
         if (tab[r].exp_word >= 0)
            chk($sformatf("row%0d_word", r), 32'(bus.out_data), 32'(tab[r].exp_word));
      end

      // Stuck source: clear the alarm, one more accepted bit completes word 4.
      run_row(tab[2]);
      status_clr = 1'b1;
      tick1();
      status_clr = 1'b0;
      chk("clr_alarm", 32'(alarm), 32'h0);
      chk("clr_count_kept", 32'(count), 32'd3);
      en = 1'b1;
      tick1();
      en = 1'b0;
      chk("clr_resume_count", 32'(count), 32'd4);

      // Full FIFO with a dropped word, then drain in order.
      run_row(tab[5]);
      bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("drain%0d_valid", k), 32'(bus.out_valid), 32'h1);
         chk($sformatf("drain%0d_data", k), 32'(bus.out_data), 32'h55);
         tick1();
      end
      chk("drain_valid_low", 32'(bus.out_valid), 32'h0);
      chk("drain_count", 32'(count), 32'h0);
      bus.out_ready = 1'b0;
      status_clr = 1'b1;
      tick1();
      status_clr = 1'b0;
      chk("clr_overflow", 32'(overflow), 32'h0);

      // Divider with a 10-cycle en pause mid-word.
      RSTn = 1'b0; ch_mask = 4'b0001; div = 8'd3; debias = 1'b0; tg = 0;
      tick1();
      RSTn = 1'b1;
      for (int c = -2; c < 42; c++) begin
         tg = ~tg; ro_in = {3'b000, tg};
         en = (c >= 0) && !(c >= 16 && c < 26);
         tick1();
         if (c == 40) chk("pause_count_before", 32'(count), 32'h0);
         if (c == 41) chk("pause_count_push", 32'(count), 32'h1);
      end
      en = 1'b0;

      // Reset mid-word: one word plus 5 bits, then reset.
      RSTn = 1'b0; div = 8'd0;
      tick1();
      RSTn = 1'b1;
      for (int c = -2; c < 13; c++) begin
         tg = ~tg; ro_in = {3'b000, tg};
         en = (c >= 0);
         tick1();
      end
      chk("pre_rst_count", 32'(count), 32'h1);
      RSTn = 1'b0; en = 1'b0;
      tick1();
      chk("rst_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_data", 32'(bus.out_data), 32'h0);
      chk("rst_flags", 32'({alarm, overflow}), 32'h0);
      RSTn = 1'b1;
      tick1();
      chk("post_rst_valid", 32'(bus.out_valid), 32'h0);
      chk("post_rst_data", 32'(bus.out_data), 32'h0);
      for (int c = 0; c < 8; c++) begin
         tg = ~tg; ro_in = {3'b000, tg};
         en = 1'b1;
         tick1();
         if (c == 6) chk("rst_word_7bits", 32'(count), 32'h0);
         if (c == 7) chk("rst_word_8bits", 32'(count), 32'h1);
      end
      en = 1'b0;

      // Randomized traffic, checked every cycle by the model.
      for (int seg = 0; seg < 20; seg++) begin
         debias  = 1'($urandom_range(0, 1));
         div     = 8'($urandom_range(0, 3));
         ch_mask = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom);
         for (int c = 0; c < 200; c++) begin
            RSTn          = ($urandom_range(0, 499) != 0);
            en            = (c != 0) && ($urandom_range(0, 7) != 0);
            ro_in         = 4'($urandom);
            bus.out_ready = ($urandom_range(0, 3) == 0);
            status_clr    = ($urandom_range(0, 63) == 0);
            tick1();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
